muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Parametrised iterative multiply/divide unit with architectural HI/LO registers; successor to the fixed single-shot mul/div path in the MIPS pipeline.
- Sits beside the execute-stage ALU; the pipeline issues an op with `start` and stalls on `busy`.
- mfhi/mflo read `hi`/`lo` directly.
- Adds signed/unsigned multiply and divide, mthi/mtlo, cancel on flush, a done pulse and a defined divide-by-zero result.

Parameters:
- WIDTH, 32, operand width; HI/LO are WIDTH bits each; iteration count = WIDTH.
- CNT_W, $clog2(WIDTH+1), width of the internal iteration counter.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only when busy=0.
- op  in  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6/7=no-op.
- srca  in  WIDTH  multiplicand/dividend; also the mthi/mtlo data.
- srcb  in  WIDTH  multiplier/divisor.
- cancel  in  1  pipeline flush; aborts any in-flight op.
- busy  out  1  high while state != IDLE (combinational from state).
- done  out  1  registered one-cycle pulse: HI/LO just updated by a mul/div.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (async, any time, including mid-operation): state=IDLE, hi=0, lo=0, done=0, counter=0. The partial result is discarded.
- FSM states: IDLE, CALC, SIGN.
- IDLE, start=1, op in 0..3 (edge 0):
  - latch operand magnitudes: |x| for signed ops, raw value for unsigned;
  - latch sign flags and op;
  - clear accumulator; counter=0; go to CALC.
- IDLE, start=1, op=4/5: hi (or lo) <= srca at that edge. No busy, no done. State stays IDLE.
- IDLE, start=1, op=6/7: ignored.
- CALC, one iteration per edge, counter increments; after WIDTH iterations (edge WIDTH) go to SIGN.
  - Multiply: radix-2 shift-add on 2*WIDTH-bit product.
  - Divide: restoring, one quotient bit per edge.
- SIGN, edge WIDTH+1:
  - Apply sign correction and write hi/lo.
  - done <= 1 for exactly one cycle; state goes to IDLE.
- Latency: busy is high for WIDTH+1 cycles after the accepting edge. With WIDTH=32, start accepted at edge 0 gives done high after edge 33.
- A new start is accepted in the same cycle that done is high.
- Results:
  - Multiply: {hi,lo} = full 2*WIDTH-bit product. For signed ops, the product is negated if operand signs differ.
  - Divide: lo = quotient, hi = remainder. The quotient is negated if signs differ; the remainder takes the sign of the dividend (truncating division).
  - Signed most-negative / -1: lo = most-negative value (wraps), hi = 0.
  - Divide by zero (DIV or DIVU): lo = all ones, hi = srca unchanged. Still takes the full latency.
- start while busy: ignored. Operand inputs are don't-care while busy.
- mthi/mtlo while busy: ignored. The pipeline must stall.
- cancel:
  - When busy, cancel → next edge state=IDLE, hi/lo keep their pre-op values, no done.
  - cancel has priority over start in the same cycle.
  - cancel has priority over the SIGN-state write, so hi/lo are not updated.
  - cancel in IDLE also blocks a same-cycle start, mthi or mtlo.

Test Plan:
- MULT srca=FFFFFFFD (-3), srcb=00000007 → after 33 busy cycles: done pulse, hi=FFFFFFFF, lo=FFFFFFEB.
- MULTU srca=srcb=FFFFFFFF → hi=FFFFFFFE, lo=00000001.
- DIV srca=FFFFFFF9 (-7), srcb=00000002 → lo=FFFFFFFD, hi=FFFFFFFF.
- DIV srca=80000000, srcb=FFFFFFFF → lo=80000000, hi=00000000.
- DIVU srca=0000000A, srcb=0 → lo=FFFFFFFF, hi=0000000A, done after the full latency.
- Preload: MTHI 12345678, MTLO 9ABCDEF0, then start MULT.
  - cancel at iteration 10 → busy drops next cycle, no done, hi=12345678, lo=9ABCDEF0.
  - Repeat the op, with reset asserted mid-CALC → hi=lo=0 and busy=0 immediately, without waiting for a clock edge.
  - Re-run with WIDTH=8: MULTU FF×FF → hi=FE, lo=01, busy high for 9 cycles.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Radix-2 shift-add multiply and restoring divide, one bit per clock, then a sign-fix cycle.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {IDLE, CALC, SIGN} state_t;

    state_t               state_q, state_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     opb_q, opb_d;
    logic                 is_div_q, is_div_d;
    logic                 neg_q, neg_d;
    logic                 neg_rem_q, neg_rem_d;
    logic                 dz_q, dz_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
    logic                 done_q, done_d;

    logic                 is_signed, sa, sb;
    logic [WIDTH-1:0]     mag_a, mag_b;
    logic [WIDTH:0]       mul_sum, div_part, div_diff;
    logic [2*WIDTH-1:0]   mul_next, div_next, prod_fix;
    logic [WIDTH-1:0]     quot_fix, rem_fix;

    // MULT and DIV are the even opcodes; unsigned variants have op[0] set.
    assign is_signed = ~op[0];
    assign sa        = is_signed & srca[WIDTH-1];
    assign sb        = is_signed & srcb[WIDTH-1];
    assign mag_a     = sa ? -srca : srca;
    assign mag_b     = sb ? -srcb : srcb;

    // Multiply: multiplier sits in the low half and shifts out as the product shifts in.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + ({1'b0, opb_q} & {(WIDTH+1){acc_q[0]}});
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Divide: remainder in the high half, dividend bits shift up while quotient bits fill in.
    assign div_part = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_diff = div_part - {1'b0, opb_q};
    assign div_next = div_diff[WIDTH] ? {div_part[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                      : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

    assign prod_fix = neg_q     ? -acc_q                  : acc_q;
    assign quot_fix = neg_q     ? -acc_q[WIDTH-1:0]       : acc_q[WIDTH-1:0];
    assign rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        opb_d     = opb_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !cancel) begin
                    if (!op[2]) begin
                        state_d   = CALC;
                        is_div_d  = op[1];
                        neg_d     = sa ^ sb;
                        neg_rem_d = sa;
                        dz_d      = op[1] && (srcb == '0);
                        opb_d     = op[1] ? mag_b : mag_a;
                        acc_d     = {{WIDTH{1'b0}}, (op[1] ? mag_a : mag_b)};
                        cnt_d     = '0;
                    end else if (op == 3'd4) begin
                        hi_d = srca;
                    end else if (op == 3'd5) begin
                        lo_d = srca;
                    end
                end
            end
            CALC: begin
                if (cancel) begin
                    state_d = IDLE;
                end else begin
                    acc_d = is_div_q ? div_next : mul_next;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d = SIGN;
                    end
                end
            end
            SIGN: begin
                state_d = IDLE;
                if (!cancel) begin
                    done_d = 1'b1;
                    if (!is_div_q) begin
                        {hi_d, lo_d} = prod_fix;
                    end else begin
                        // Divide by zero leaves an all-ones quotient; the remainder is the dividend.
                        lo_d = dz_q ? {WIDTH{1'b1}} : quot_fix;
                        hi_d = rem_fix;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            opb_q     <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            opb_q     <= opb_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: table-driven and random ops through a scoreboard, plus
// hand-written cancel, reset and mthi/mtlo sequences, and a WIDTH=8 instance.
module tb_muldiv_unit;

    logic        clk, reset;
    logic        start, cancel;
    logic [2:0]  op;
    logic [31:0] srca, srcb;
    logic        busy, done;
    logic [31:0] hi, lo;

    logic        start8, cancel8;
    logic [2:0]  op8;
    logic [7:0]  srca8, srcb8;
    logic        busy8, done8;
    logic [7:0]  hi8, lo8;

    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0] exp_q[$];

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .srca(srca), .srcb(srcb),
        .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    muldiv_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .op(op8), .srca(srca8), .srcb(srcb8),
        .cancel(cancel8), .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eh;
        logic [31:0] el;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] eh, output logic [31:0] el);
        longint          ps;
        longint unsigned pu;
        int              qa, qb;
        eh = '0;
        el = '0;
        case (o)
            3'd0: begin
                ps = longint'($signed(a)) * longint'($signed(b));
                {eh, el} = ps;
            end
            3'd1: begin
                pu = {32'd0, a} * {32'd0, b};
                {eh, el} = pu;
            end
            3'd2: begin
                qa = a;
                qb = b;
                if (b == 32'd0) begin
                    el = 32'hFFFF_FFFF; eh = a;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    el = 32'h8000_0000; eh = 32'd0;
                end else begin
                    el = qa / qb; eh = qa % qb;
                end
            end
            default: begin
                if (b == 32'd0) begin
                    el = 32'hFFFF_FFFF; eh = a;
                end else begin
                    el = a / b; eh = a % b;
                end
            end
        endcase
    endfunction

    // Issue one op. With cancel_at>0 the op is flushed after that many busy cycles and
    // eh/el are the values hi/lo must keep. With b2b the start is driven in the done cycle.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el,
                          input int cancel_at, input bit b2b);
        int cyc, n;
        logic [63:0] e;
        if (!b2b) @(negedge clk);
        op = o; srca = a; srcb = b; start = 1'b1;
        if (cancel_at == 0) exp_q.push_back({eh, el});
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        n = 0;
        while (!done && n < 100) begin
            if (busy) cyc++;
            // Stray mthi requests while busy must be ignored.
            start = busy && cyc >= 2 && cyc < 25;
            op = 3'd4;
            srca = $urandom;
            srcb = $urandom;
            if (cancel_at != 0 && cyc == cancel_at) begin
                start = 1'b0;
                cancel = 1'b1;
                @(negedge clk);
                cancel = 1'b0;
                check("cancel_busy", {63'd0, busy}, 64'd0);
                for (int k = 0; k < 40; k++) begin
                    if (done) check("cancel_no_done", {63'd0, done}, 64'd0);
                    @(negedge clk);
                end
                check("cancel_hi", {32'd0, hi}, {32'd0, eh});
                check("cancel_lo", {32'd0, lo}, {32'd0, el});
                $display("op=%0d a=%h b=%h cancelled after %0d busy cycles hi=%h lo=%h", o, a, b, cyc, hi, lo);
                return;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check("latency", cyc, 33);
        check("done", {63'd0, done}, 64'd1);
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 64'd0, 64'd1);
        end else begin
            e = exp_q.pop_front();
            check("hi", {32'd0, hi}, {32'd0, e[63:32]});
            check("lo", {32'd0, lo}, {32'd0, e[31:0]});
        end
        $display("op=%0d a=%h b=%h busy=%0d hi=%h lo=%h", o, a, b, cyc, hi, lo);
    endtask

    initial begin
        vec_t        vecs[11];
        logic [2:0]  ro;
        logic [31:0] ra, rb, rh, rl;
        int          cyc, n;

        vecs[0]  = '{3'd0, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[1]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[2]  = '{3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3]  = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[4]  = '{3'd3, 32'h0000_000A, 32'h0000_0000, 32'h0000_000A, 32'hFFFF_FFFF};
        vecs[5]  = '{3'd2, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[6]  = '{3'd2, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
        vecs[7]  = '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[8]  = '{3'd3, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E};
        vecs[9]  = '{3'd0, 32'h0000_0003, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
        vecs[10] = '{3'd1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000};

        reset = 1'b1; start = 1'b0; cancel = 1'b0; op = 3'd6; srca = '0; srcb = '0;
        start8 = 1'b0; cancel8 = 1'b0; op8 = 3'd6; srca8 = '0; srcb8 = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_hi", {32'd0, hi}, 64'd0);
        check("rst_lo", {32'd0, lo}, 64'd0);
        reset = 1'b0;

        for (int i = 0; i < 11; i++)
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].eh, vecs[i].el, 0, i > 0);

        for (int i = 0; i < 6; i++) begin
            ro = 3'($urandom_range(0, 3));
            ra = $urandom;
            rb = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
            model(ro, ra, rb, rh, rl);
            run_op(ro, ra, rb, rh, rl, 0, 1'b0);
        end

        // mthi / mtlo preload
        @(negedge clk);
        op = 3'd4; srca = 32'h1234_5678; start = 1'b1;
        @(negedge clk);
        op = 3'd5; srca = 32'h9ABC_DEF0;
        check("mthi_hi", {32'd0, hi}, 64'h1234_5678);
        check("mthi_busy", {63'd0, busy}, 64'd0);
        @(negedge clk);
        start = 1'b0;
        check("mtlo_lo", {32'd0, lo}, 64'h9ABC_DEF0);
        check("mtlo_done", {63'd0, done}, 64'd0);
        $display("mthi/mtlo hi=%h lo=%h", hi, lo);

        // cancel in IDLE blocks mthi and mul start
        op = 3'd4; srca = 32'hDEAD_BEEF; start = 1'b1; cancel = 1'b1;
        @(negedge clk);
        op = 3'd0;
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        check("idle_cancel_hi", {32'd0, hi}, 64'h1234_5678);
        check("idle_cancel_busy", {63'd0, busy}, 64'd0);
        $display("idle cancel hi=%h busy=%0d", hi, busy);

        run_op(3'd0, 32'hFFFF_FFFD, 32'h0000_0007, 32'h1234_5678, 32'h9ABC_DEF0, 10, 1'b0);
        run_op(3'd0, 32'hFFFF_FFFD, 32'h0000_0007, 32'h1234_5678, 32'h9ABC_DEF0, 33, 1'b0);

        // asynchronous reset mid-CALC
        op = 3'd0; srca = 32'hFFFF_FFFD; srcb = 32'h0000_0007; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("pre_rst_busy", {63'd0, busy}, 64'd1);
        #1 reset = 1'b1;
        #1;
        check("async_rst_busy", {63'd0, busy}, 64'd0);
        check("async_rst_hi", {32'd0, hi}, 64'd0);
        check("async_rst_lo", {32'd0, lo}, 64'd0);
        $display("async reset busy=%0d hi=%h lo=%h", busy, hi, lo);
        @(negedge clk);
        reset = 1'b0;

        // WIDTH=8 instance
        @(negedge clk);
        op8 = 3'd1; srca8 = 8'hFF; srcb8 = 8'hFF; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        cyc = 0;
        n = 0;
        while (!done8 && n < 50) begin
            if (busy8) cyc++;
            @(negedge clk);
            n++;
        end
        check("w8_latency", cyc, 9);
        check("w8_done", {63'd0, done8}, 64'd1);
        check("w8_hi", {56'd0, hi8}, 64'hFE);
        check("w8_lo", {56'd0, lo8}, 64'h01);
        $display("w8 multu ff*ff busy=%0d hi=%h lo=%h", cyc, hi8, lo8);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
